mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Memory-side responder for the cache request interface. Two requesters share
// one RAM port:
//   - dcache : word reads and writes (dREN / dWEN, daddr, dstore)
//   - icache : word reads only       (iREN, iaddr)
//
// A three-state FSM (IDLE / DACC / IACC) picks one requester per access.
// Arbitration happens only in IDLE and is registered on the clock edge, so a
// request seen in cycle N drives the RAM strobe from cycle N+1. Every access
// returns to IDLE for one turnaround cycle before the next grant.
//
// The dcache normally wins. A starve counter counts consecutive dcache grants
// taken while iREN is pending. Once it reaches STARVE, the icache is forced in.
//
// The RAM-side outputs and the wait/load handshakes are driven
// combinationally from the registered state and the live request inputs.
// This gives:
//   - completion in the same cycle that ramready rises;
//   - strobes that drop in the same cycle a dcache request is withdrawn.
// In IDLE every output sits at its reset value, so an asynchronous reset
// (which forces IDLE) also returns all outputs to their reset values at once.
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned STARVE = 4,   // 1..15
    parameter int unsigned AW     = 32
) (
    input  logic          CLK,
    input  logic          nRST,
    // dcache side
    input  logic          dREN,
    input  logic          dWEN,
    input  logic [AW-1:0] daddr,
    input  logic [31:0]   dstore,
    output logic          dwait,
    output logic [31:0]   dload,
    // icache side
    input  logic          iREN,
    input  logic [AW-1:0] iaddr,
    output logic          iwait,
    output logic [31:0]   iload,
    // RAM side
    output logic          ramREN,
    output logic          ramWEN,
    output logic [AW-1:0] ramaddr,
    output logic [31:0]   ramstore,
    input  logic [31:0]   ramload,
    input  logic          ramready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2
    } state_t;

    // Starve threshold at the counter's own width (STARVE never exceeds 15).
    localparam logic [3:0] STARVE_L = 4'(STARVE);

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  starve_r;
    logic [3:0]  starve_s;

    logic        dreq_s;
    logic        ireq_s;
    logic        ddone_s;
    logic        idone_s;
    logic [AW-1:0] daddr_word_s;
    logic [AW-1:0] iaddr_word_s;

    // Byte-offset bits of the word addresses are deliberately dropped.
    logic        unused_addr_lsbs_s;

    // Request and completion qualifiers shared by the next-state and output logic.
    always_comb begin
        dreq_s       = dREN | dWEN;
        ireq_s       = iREN;
        // An access only completes if its requester is still asking for it.
        // A withdrawn request is an abort, even if ramready arrives with it.
        ddone_s      = (state_r == DACC) & dreq_s & ramready;
        idone_s      = (state_r == IACC) & ireq_s & ramready;
        daddr_word_s = {daddr[AW-1:2], 2'b00};
        iaddr_word_s = {iaddr[AW-1:2], 2'b00};
        unused_addr_lsbs_s = ^{daddr[1:0], iaddr[1:0]};
    end

    // State and starve-counter registers; async reset returns to IDLE with a clear counter.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r  <= IDLE;
            starve_r <= 4'd0;
        end else begin
            state_r  <= state_s;
            starve_r <= starve_s;
        end
    end

    // Next-state arbitration and starve-counter update.
    always_comb begin
        state_s  = state_r;
        starve_s = starve_r;
        case (state_r)
            IDLE: begin
                // Starvation is only tracked while the icache is actually waiting.
                if (!ireq_s) begin
                    starve_s = 4'd0;
                end else begin
                    starve_s = starve_r;
                end

                if (dreq_s && !ireq_s) begin
                    state_s = DACC;
                end else if (ireq_s && !dreq_s) begin
                    state_s  = IACC;
                    starve_s = 4'd0;
                end else if (dreq_s && ireq_s) begin
                    if (starve_r < STARVE_L) begin
                        // The dcache keeps priority.
                        // The counter cannot pass STARVE_L, so it saturates.
                        state_s  = DACC;
                        starve_s = starve_r + 4'd1;
                    end else begin
                        state_s  = IACC;
                        starve_s = 4'd0;
                    end
                end else begin
                    state_s = IDLE;
                end
            end

            DACC: begin
                // Leave on completion or on abort (request withdrawn).
                if (!dreq_s || ramready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DACC;
                end
            end

            IACC: begin
                if (!ireq_s || ramready) begin
                    state_s = IDLE;
                end else begin
                    state_s = IACC;
                end
            end

            default: begin
                state_s  = IDLE;
                starve_s = 4'd0;
            end
        endcase
    end

    // RAM port and cache handshakes.
    // IDLE leaves everything at reset values; the granted source passes through.
    always_comb begin
        dwait    = 1'b1;
        iwait    = 1'b1;
        dload    = 32'd0;
        iload    = 32'd0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = {AW{1'b0}};
        ramstore = 32'd0;
        case (state_r)
            IDLE: begin
                // ramready arriving here is ignored: no handshake is produced.
                dwait = 1'b1;
                iwait = 1'b1;
            end

            DACC: begin
                ramaddr  = daddr_word_s;
                ramstore = dstore;
                // A write takes precedence when both strobes are asserted.
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (ddone_s) begin
                    dwait = 1'b0;
                    dload = ramload;
                end else begin
                    dwait = 1'b1;
                    dload = 32'd0;
                end
            end

            IACC: begin
                ramaddr = iaddr_word_s;
                ramREN  = 1'b1;
                if (idone_s) begin
                    iwait = 1'b0;
                    iload = ramload;
                end else begin
                    iwait = 1'b1;
                    iload = 32'd0;
                end
            end

            default: begin
                dwait = 1'b1;
                iwait = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter (STARVE = 4, AW = 32). It runs:
//   1. a directed cycle table with hand-derived expectations;
//   2. a starvation grant-order sequence;
//   3. an asynchronous reset taken during an icache access;
//   4. a randomized phase checked against a behavioural model.
//
// The model only tracks:
//   - which requester currently owns the RAM port;
//   - how many dcache grants in a row were taken while the icache waited.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int STARVE = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        dREN, dWEN, iREN, ramready;
    logic [31:0] daddr, dstore, iaddr, ramload;
    logic        dwait, iwait, ramREN, ramWEN;
    logic [31:0] dload, iload, ramaddr, ramstore;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.STARVE(STARVE), .AW(32)) dut (
        .CLK(CLK), .nRST(nRST),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramready(ramready)
    );

    always #5 CLK = ~CLK;

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        dren, dwen, iren, rdy;
        logic [31:0] daddr, dstore, iaddr, rload;
        logic        e_dwait, e_iwait, e_ren, e_wen;
        logic [31:0] e_addr, e_store, e_dload, e_iload;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic dr, input logic dw, input logic [31:0] da,
                       input logic [31:0] ds, input logic ir, input logic [31:0] ia,
                       input logic rd, input logic [31:0] rl,
                       input logic edw, input logic eiw, input logic er, input logic ew,
                       input logic [31:0] ea, input logic [31:0] es,
                       input logic [31:0] edl, input logic [31:0] eil);
        vec_t v;
        v.dren = dr; v.dwen = dw; v.daddr = da; v.dstore = ds;
        v.iren = ir; v.iaddr = ia; v.rdy = rd; v.rload = rl;
        v.e_dwait = edw; v.e_iwait = eiw; v.e_ren = er; v.e_wen = ew;
        v.e_addr = ea; v.e_store = es; v.e_dload = edl; v.e_iload = eil;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int m_owner = 0;   // 0 = nobody, 1 = dcache, 2 = icache
    int m_run   = 0;   // dcache grants in a row while icache waited

    logic        e_dwait, e_iwait, e_ren, e_wen;
    logic [31:0] e_addr, e_store, e_dload, e_iload;

    task automatic model_expect();
        e_dwait = 1'b1; e_iwait = 1'b1; e_ren = 1'b0; e_wen = 1'b0;
        e_addr = 32'd0; e_store = 32'd0; e_dload = 32'd0; e_iload = 32'd0;
        if (m_owner == 1) begin
            e_addr  = daddr & 32'hFFFF_FFFC;
            e_store = dstore;
            e_wen   = dWEN;
            e_ren   = dREN & !dWEN;
            if ((dREN || dWEN) && ramready) begin
                e_dwait = 1'b0;
                e_dload = ramload;
            end
        end else if (m_owner == 2) begin
            e_addr = iaddr & 32'hFFFF_FFFC;
            e_ren  = 1'b1;
            if (iREN && ramready) begin
                e_iwait = 1'b0;
                e_iload = ramload;
            end
        end
    endtask

    task automatic model_clock();
        bit d, i;
        d = dREN || dWEN;
        i = iREN;
        if (!nRST) begin
            m_owner = 0; m_run = 0;
        end else if (m_owner == 0) begin
            if (d && i && m_run < STARVE) begin
                m_owner = 1; m_run++;
            end else if (i) begin
                m_owner = (d || i) ? 2 : 0;
                m_run   = 0;
            end else if (d) begin
                m_owner = 1;
            end
            if (!i) m_run = 0;
        end else if (m_owner == 1) begin
            if (!d || ramready) m_owner = 0;
        end else begin
            if (!i || ramready) m_owner = 0;
        end
    endtask

    task automatic check_model(input string tag);
        model_expect();
        check({tag, ".dwait"},    {31'd0, dwait},  {31'd0, e_dwait});
        check({tag, ".iwait"},    {31'd0, iwait},  {31'd0, e_iwait});
        check({tag, ".ramREN"},   {31'd0, ramREN}, {31'd0, e_ren});
        check({tag, ".ramWEN"},   {31'd0, ramWEN}, {31'd0, e_wen});
        check({tag, ".ramaddr"},  ramaddr,  e_addr);
        check({tag, ".ramstore"}, ramstore, e_store);
        check({tag, ".dload"},    dload,    e_dload);
        check({tag, ".iload"},    iload,    e_iload);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".dwait"},    {31'd0, dwait},  32'd1);
        check({tag, ".iwait"},    {31'd0, iwait},  32'd1);
        check({tag, ".ramREN"},   {31'd0, ramREN}, 32'd0);
        check({tag, ".ramWEN"},   {31'd0, ramWEN}, 32'd0);
        check({tag, ".ramaddr"},  ramaddr,  32'd0);
        check({tag, ".ramstore"}, ramstore, 32'd0);
        check({tag, ".dload"},    dload,    32'd0);
        check({tag, ".iload"},    iload,    32'd0);
    endtask

    // One clock: the model follows the edge, inputs change 1 time unit later.
    task automatic tick();
        @(posedge CLK);
        model_clock();
        #1;
    endtask

    task automatic idle_inputs();
        dREN = 1'b0; dWEN = 1'b0; iREN = 1'b0; ramready = 1'b0;
        daddr = 32'd0; dstore = 32'd0; iaddr = 32'd0; ramload = 32'd0;
    endtask

    int grants[$];
    int budget;
    int got;

    initial begin
        nRST = 1'b0;
        idle_inputs();
        #3;
        check_reset_vals("reset");
        @(negedge CLK);
        nRST = 1'b1;
        tick();

        // -------- directed table --------
        //   dR dW daddr         dstore  iR iaddr  rdy ramload        | dw iw REN WEN ramaddr  store  dload          iload
        add(0, 0, 32'h0,        32'h0,  0, 32'h0, 0, 32'h0,          1, 1, 0, 0, 32'h0,   32'h0,  32'h0,         32'h0);
        // single dcache read of 0x104, ready on the second strobe cycle
        add(1, 0, 32'h104,      32'h0,  0, 32'h0, 0, 32'h0,          1, 1, 0, 0, 32'h0,   32'h0,  32'h0,         32'h0);
        add(1, 0, 32'h104,      32'h0,  0, 32'h0, 0, 32'h0,          1, 1, 1, 0, 32'h104, 32'h0,  32'h0,         32'h0);
        add(1, 0, 32'h104,      32'h0,  0, 32'h0, 1, 32'hDEADBEEF,   0, 1, 1, 0, 32'h104, 32'h0,  32'hDEADBEEF,  32'h0);
        add(0, 0, 32'h0,        32'h0,  0, 32'h0, 0, 32'h0,          1, 1, 0, 0, 32'h0,   32'h0,  32'h0,         32'h0);
        // write-back burst 0x200 / 0x204 with an IDLE cycle in between
        add(0, 1, 32'h200,      32'h11, 0, 32'h0, 0, 32'h0,          1, 1, 0, 0, 32'h0,   32'h0,  32'h0,         32'h0);
        add(0, 1, 32'h200,      32'h11, 0, 32'h0, 0, 32'h0,          1, 1, 0, 1, 32'h200, 32'h11, 32'h0,         32'h0);
        add(0, 1, 32'h200,      32'h11, 0, 32'h0, 1, 32'h0,          0, 1, 0, 1, 32'h200, 32'h11, 32'h0,         32'h0);
        add(0, 1, 32'h204,      32'h22, 0, 32'h0, 0, 32'h0,          1, 1, 0, 0, 32'h0,   32'h0,  32'h0,         32'h0);
        add(0, 1, 32'h204,      32'h22, 0, 32'h0, 0, 32'h0,          1, 1, 0, 1, 32'h204, 32'h22, 32'h0,         32'h0);
        add(0, 1, 32'h204,      32'h22, 0, 32'h0, 1, 32'h0,          0, 1, 0, 1, 32'h204, 32'h22, 32'h0,         32'h0);
        add(0, 0, 32'h0,        32'h0,  0, 32'h0, 0, 32'h0,          1, 1, 0, 0, 32'h0,   32'h0,  32'h0,         32'h0);
        // unaligned address with both dREN and dWEN: word-aligned write
        add(1, 1, 32'h107,      32'h5A, 0, 32'h0, 0, 32'h0,          1, 1, 0, 0, 32'h0,   32'h0,  32'h0,         32'h0);
        add(1, 1, 32'h107,      32'h5A, 0, 32'h0, 0, 32'h0,          1, 1, 0, 1, 32'h104, 32'h5A, 32'h0,         32'h0);
        add(1, 1, 32'h107,      32'h5A, 0, 32'h0, 1, 32'h0,          0, 1, 0, 1, 32'h104, 32'h5A, 32'h0,         32'h0);
        add(0, 0, 32'h0,        32'h0,  0, 32'h0, 0, 32'h0,          1, 1, 0, 0, 32'h0,   32'h0,  32'h0,         32'h0);
        // dcache read withdrawn mid-access, then a late ramready in IDLE
        add(1, 0, 32'h300,      32'h0,  0, 32'h0, 0, 32'h0,          1, 1, 0, 0, 32'h0,   32'h0,  32'h0,         32'h0);
        add(1, 0, 32'h300,      32'h0,  0, 32'h0, 0, 32'h0,          1, 1, 1, 0, 32'h300, 32'h0,  32'h0,         32'h0);
        add(0, 0, 32'h300,      32'h0,  0, 32'h0, 0, 32'h0,          1, 1, 0, 0, 32'h300, 32'h0,  32'h0,         32'h0);
        add(0, 0, 32'h0,        32'h0,  0, 32'h0, 1, 32'hBAD,        1, 1, 0, 0, 32'h0,   32'h0,  32'h0,         32'h0);
        add(0, 0, 32'h0,        32'h0,  0, 32'h0, 0, 32'h0,          1, 1, 0, 0, 32'h0,   32'h0,  32'h0,         32'h0);
        // single icache read of 0x88 with immediate ready
        add(0, 0, 32'h0,        32'h0,  1, 32'h8A, 0, 32'h0,         1, 1, 0, 0, 32'h0,   32'h0,  32'h0,         32'h0);
        add(0, 0, 32'h0,        32'h0,  1, 32'h8A, 1, 32'h1234,      1, 0, 1, 0, 32'h88,  32'h0,  32'h0,         32'h1234);
        add(0, 0, 32'h0,        32'h0,  0, 32'h0, 0, 32'h0,          1, 1, 0, 0, 32'h0,   32'h0,  32'h0,         32'h0);

        for (int k = 0; k < vecs.size(); k++) begin
            dREN = vecs[k].dren; dWEN = vecs[k].dwen; daddr = vecs[k].daddr;
            dstore = vecs[k].dstore; iREN = vecs[k].iren; iaddr = vecs[k].iaddr;
            ramready = vecs[k].rdy; ramload = vecs[k].rload;
            @(negedge CLK);
            check($sformatf("vec%0d.dwait", k),    {31'd0, dwait},  {31'd0, vecs[k].e_dwait});
            check($sformatf("vec%0d.iwait", k),    {31'd0, iwait},  {31'd0, vecs[k].e_iwait});
            check($sformatf("vec%0d.ramREN", k),   {31'd0, ramREN}, {31'd0, vecs[k].e_ren});
            check($sformatf("vec%0d.ramWEN", k),   {31'd0, ramWEN}, {31'd0, vecs[k].e_wen});
            check($sformatf("vec%0d.ramaddr", k),  ramaddr,  vecs[k].e_addr);
            check($sformatf("vec%0d.ramstore", k), ramstore, vecs[k].e_store);
            check($sformatf("vec%0d.dload", k),    dload,    vecs[k].e_dload);
            check($sformatf("vec%0d.iload", k),    iload,    vecs[k].e_iload);
            tick();
        end

        // -------- starvation: both requesting, immediate ready --------
        dREN = 1'b1; iREN = 1'b1; daddr = 32'h500; iaddr = 32'h600; ramready = 1'b1;
        budget = 0;
        while (grants.size() < 10 && budget < 60) begin
            ramload = $urandom;
            @(negedge CLK);
            check_model("starve");
            if (!dwait) grants.push_back(1);
            if (!iwait) begin
                grants.push_back(2);
                check("starve.iload", iload, ramload);
            end
            tick();
            budget++;
        end
        for (int k = 0; k < 10; k++) begin
            got = (k < grants.size()) ? grants[k] : 0;
            check($sformatf("starve.grant%0d", k), got, (k == 4 || k == 9) ? 32'd2 : 32'd1);
        end

        // -------- async reset during an icache access --------
        idle_inputs();
        tick();
        tick();
        iREN = 1'b1; iaddr = 32'h44;
        @(negedge CLK);
        check_model("rst.idle");
        tick();
        @(negedge CLK);
        check("rst.iacc_ren", {31'd0, ramREN}, 32'd1);
        check("rst.iacc_addr", ramaddr, 32'h44);
        #2;
        nRST = 1'b0;
        m_owner = 0; m_run = 0;
        #1;
        check_reset_vals("rst.async");
        tick();
        @(negedge CLK);
        check_reset_vals("rst.held");
        #1;
        nRST = 1'b1;
        tick();
        @(negedge CLK);
        check_model("rst.after_idle");
        tick();
        ramready = 1'b1; ramload = 32'hCAFEF00D;
        @(negedge CLK);
        check_model("rst.after_iacc");
        check("rst.new_iwait", {31'd0, iwait}, 32'd0);
        check("rst.new_iload", iload, 32'hCAFEF00D);
        tick();
        idle_inputs();

        // -------- randomized phase against the model --------
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 4) == 0) dREN = ~dREN;
            if ($urandom_range(0, 6) == 0) dWEN = ~dWEN;
            if ($urandom_range(0, 4) == 0) iREN = ~iREN;
            if ($urandom_range(0, 7) == 0) daddr = $urandom;
            if ($urandom_range(0, 7) == 0) iaddr = $urandom;
            dstore   = $urandom;
            ramload  = $urandom;
            ramready = ($urandom_range(0, 9) < 4);
            if (!nRST) begin
                nRST = 1'b1;
            end else if ($urandom_range(0, 199) == 0) begin
                nRST = 1'b0;
                m_owner = 0; m_run = 0;
            end
            @(negedge CLK);
            check_model("rand");
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
